serial_alu_dig: RTL and testbench
=================================

Name: serial_alu_dig

Overview:
- Parametrised digit-serial ALU. Processes WIDTH-bit operands LSB-first, DIGIT bits per clock.
- Adds an internal digit counter, a start/done handshake, result flags and a Booth-step mode that keeps multiplier-bit history across operations.
- Sits between the array register file (serial read/write ports) and the array controller.
- Replaces the external count/OpStart coupling with a self-timed sequencer.

Parameters:
- WIDTH, 64: operand width in bits; must be a multiple of DIGIT (elaboration error otherwise).
- DIGIT, 1: bits consumed and produced per cycle; allowed values are 1, 2, 4 and 8.
- NDIG, WIDTH/DIGIT: derived local constant, not overridable.

Ports:
- clk  in  1  rising-edge clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation; accepted only when busy=0.
- op  in  3  operation code, sampled at accepted start.
- booth_clr  in  1  synchronous clear of the Booth history bit q0; ignored while busy=1.
- rs1_d  in  DIGIT  operand-A digit, LSB-first.
- rs2_d  in  DIGIT  operand-B digit, LSB-first.
- busy  out  1  operation in progress; start is ignored while high.
- rd_d  out  DIGIT  registered result digit.
- rd_valid  out  1  rd_d holds a valid digit (register-file write enable).
- done  out  1  single-cycle pulse, coincident with the last rd_valid.
- flag_c  out  1  ADD: carry out. SUB: borrow (1 when rs1 < rs2 unsigned). Valid with done, held until the next done.
- flag_z  out  1  whole result equals zero. Valid with done, held.
- flag_v  out  1  signed overflow for ADD/SUB; 0 for all other ops. Valid with done, held.
- booth_noop  out  1  last BOOTH op resolved to pass. Valid with done, held.

Behaviour:
- Reset (asynchronous, reset=0) forces: busy=0, rd_d=0, rd_valid=0, done=0, all flags=0, booth_noop=0, q0=0, q1=0, carry=0, digit counter=0, state IDLE. Reset mid-operation aborts the operation; no done is issued.
- Op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS (rd=rs1), 6 BOOTH, 7 reserved (executes as PASS).
- Sequencing:
  - Start is accepted in cycle T0 when start=1 and busy=0. In T0, rs1_d/rs2_d carry digit 0.
  - Cycles T1..T(NDIG-1) carry digits 1..NDIG-1. The source must present them on consecutive cycles; there is no stall.
  - busy=1 during T1..T(NDIG-1). For NDIG=1, busy stays 0.
  - Digit k appears on rd_d with rd_valid=1 in cycle T(k+1); latency is 1 cycle.
  - done=1 in T(NDIG).
- Back-to-back: a start in T(NDIG) is accepted, giving one operation every NDIG cycles with no bubble.
- A start while busy=1 is ignored silently; op is not re-sampled.
- Arithmetic:
  - Ripple carry across the DIGIT bits within a cycle; the carry register is chained between digits.
  - Carry-in for digit 0: ADD=0; SUB=1 (SUB computes rs1 + ~rs2 + 1).
  - flag_c for SUB is the inverted final carry.
  - flag_v = carry into MSB XOR carry out of MSB, taken on the last digit.
  - flag_z is accumulated as the OR of all result digits, then inverted at done.
- BOOTH mode:
  - At T0, q1 <= rs2_d[0].
  - Decision (q1,q0) is made combinationally from the new q1 for all digits: 10 -> SUB, 01 -> ADD, 00/11 -> PASS with booth_noop=1.
  - Carry-in follows the resolved op. Flags follow the resolved op.
  - At done, q0 <= q1.
  - booth_clr=1 with busy=0 sets q0=0. If it coincides with an accepted start, the clear applies before the decision.
- Non-BOOTH ops leave q0 and q1 unchanged.
- The state machine is IDLE/RUN, with done derived from the counter. The counter wraps to 0 at T(NDIG); no overflow beyond NDIG-1.

Decomposition:
- Package serial_alu_pkg holds:
  - the op encoding localparams (OP_ADD..OP_BOOTH);
  - the state encoding;
  - a function that resolves (op, q1, q0) to an effective op and carry-in.
- One sub-module, serial_add_digit: combinational DIGIT-bit adder with cin/cout and MSB carry-in output for overflow. Instantiated once.
- Sequencer, flags and Booth history stay in the top module.

Test Plan:
- WIDTH=8, DIGIT=2, ADD 0x7F+0x01 -> rd digits 00,00,00,10 in T1..T4; done in T4; flag_c=0, flag_z=0, flag_v=1.
- SUB 0x05-0x07 -> result 0xFE; flag_c=1, flag_v=0, flag_z=0. Then AND 0xF0&0x0F -> 0x00 with flag_z=1, issued back-to-back with the start in the previous op's done cycle.
- BOOTH chain, starting with booth_clr:
  - rs2=0x01, rs1=0x10 -> rd=0x10-0x01=0x0F.
  - rs2=0x02 -> (0,1) gives ADD.
  - rs2=0x04 -> (0,0) gives rd=rs1 and booth_noop=1.
- start pulsed at T1 and T2 of a running ADD -> ignored. Exactly one done; op unchanged.
- Assert reset=0 asynchronously mid-T2 -> busy, rd_valid and rd_d go 0 immediately with no done; q0=0. A fresh ADD 0x01+0x01 afterwards yields 0x02.
- WIDTH=64, DIGIT=1, ADD 0xFFFF_FFFF_FFFF_FFFF + 1 -> 64 zero digits; done at T64; flag_c=1, flag_z=1.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// Shared definitions for the digit-serial ALU: op codes, sequencer states
// and the Booth-aware op resolver.
package serial_alu_pkg;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_PASS  = 3'd5;
  localparam logic [2:0] OP_BOOTH = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  typedef struct packed {
    logic [2:0] op;
    logic       cin;
  } eff_t;

  // Maps the requested op plus Booth history (q1,q0) to the op actually executed.
  function automatic eff_t resolve_op(logic [2:0] op, logic q1, logic q0);
    eff_t r;
    r.op = op;
    if (op == OP_BOOTH) begin
      case ({q1, q0})
        2'b10:   r.op = OP_SUB;
        2'b01:   r.op = OP_ADD;
        default: r.op = OP_PASS;
      endcase
    end else if (op == OP_RSVD) begin
      r.op = OP_PASS;
    end
    r.cin = (r.op == OP_SUB);
    return r;
  endfunction

endpackage

// File: rtl/serial_add_digit.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into the MSB
// so the caller can form signed overflow.
module serial_add_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  always_comb begin : p_add
    logic cy;
    cy   = cin;
    cmsb = cin;
    sum  = '0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) cmsb = cy;
      sum[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | (a[i] & cy) | (b[i] & cy);
    end
    cout = cy;
  end

endmodule

// File: rtl/serial_alu_dig.sv
// Digit-serial ALU: WIDTH-bit operands streamed LSB-first, DIGIT bits per
// cycle, self-timed with a start/busy/done handshake and Booth-step history.
module serial_alu_dig
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             booth_clr,
  input  logic [DIGIT-1:0] rs1_d,
  input  logic [DIGIT-1:0] rs2_d,
  output logic             busy,
  output logic [DIGIT-1:0] rd_d,
  output logic             rd_valid,
  output logic             done,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_v,
  output logic             booth_noop
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if ((WIDTH % DIGIT) != 0 || !(DIGIT == 1 || DIGIT == 2 || DIGIT == 4 || DIGIT == 8))
  begin : g_param_err
    $error("serial_alu_dig: WIDTH must be a multiple of DIGIT, DIGIT in {1,2,4,8}");
  end

  state_t     state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  eff_t       eff_q, res0;
  logic       booth_q, carry_q, zacc, q0, q1;

  logic       accept, active, last;
  logic       q0_eff, q1_new, q1_cur, cur_booth, cur_cin, zin;
  logic [2:0] cur_op;
  logic [DIGIT-1:0] b_in, sum, res_d;
  logic       cout, cmsb;

  assign busy   = (state == S_RUN);
  assign accept = start & ~busy;
  assign active = accept | busy;

  // A clear coinciding with an accepted start takes effect before the decision.
  assign q0_eff = booth_clr ? 1'b0 : q0;
  assign q1_new = (op == OP_BOOTH) ? rs2_d[0] : q1;
  assign res0   = resolve_op(op, q1_new, q0_eff);

  assign cur_op    = busy ? eff_q.op : res0.op;
  assign cur_cin   = busy ? carry_q  : res0.cin;
  assign cur_booth = busy ? booth_q  : (op == OP_BOOTH);
  assign q1_cur    = busy ? q1       : q1_new;
  assign zin       = busy ? zacc     : 1'b0;
  assign last      = busy ? (cnt == LAST) : (NDIG == 1);

  assign b_in = (cur_op == OP_SUB) ? ~rs2_d : rs2_d;

  serial_add_digit #(.DIGIT(DIGIT)) u_add (
    .a    (rs1_d),
    .b    (b_in),
    .cin  (cur_cin),
    .sum  (sum),
    .cout (cout),
    .cmsb (cmsb)
  );

  always_comb begin
    res_d = rs1_d;
    case (cur_op)
      OP_ADD, OP_SUB: res_d = sum;
      OP_AND:         res_d = rs1_d & rs2_d;
      OP_OR:          res_d = rs1_d | rs2_d;
      OP_XOR:         res_d = rs1_d ^ rs2_d;
      default:        res_d = rs1_d;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        if (accept && NDIG > 1) begin
          state_nx = S_RUN;
          cnt_nx   = CW'(1);
        end
      end
      S_RUN: begin
        if (cnt == LAST) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_d       <= '0;
      rd_valid   <= 1'b0;
      done       <= 1'b0;
      flag_c     <= 1'b0;
      flag_z     <= 1'b0;
      flag_v     <= 1'b0;
      booth_noop <= 1'b0;
      q0         <= 1'b0;
      q1         <= 1'b0;
      carry_q    <= 1'b0;
      zacc       <= 1'b0;
      booth_q    <= 1'b0;
      eff_q      <= '0;
    end else begin
      rd_valid <= active;
      done     <= active & last;
      if (active) begin
        rd_d    <= res_d;
        carry_q <= cout;
        zacc    <= zin | (|res_d);
      end
      if (accept) begin
        eff_q   <= res0;
        booth_q <= (op == OP_BOOTH);
        if (op == OP_BOOTH) q1 <= rs2_d[0];
      end
      if (!busy && booth_clr) q0 <= 1'b0;
      // History update on the last digit overrides a same-cycle clear (NDIG=1).
      if (active && last) begin
        flag_c     <= (cur_op == OP_ADD) ? cout : ((cur_op == OP_SUB) ? ~cout : 1'b0);
        flag_v     <= (cur_op == OP_ADD || cur_op == OP_SUB) ? (cmsb ^ cout) : 1'b0;
        flag_z     <= ~(zin | (|res_d));
        booth_noop <= cur_booth && (cur_op == OP_PASS);
        if (cur_booth) q0 <= q1_cur;
      end
    end
  end

endmodule

// File: tb/tb_serial_alu_dig.sv
// Bench for serial_alu_dig: an 8-bit/2-bit-digit instance and a 64-bit/1-bit
// instance checked against a word-level arithmetic model.
module tb_serial_alu_dig;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       s8_start, s8_clr, s8_busy, s8_valid, s8_done, s8_c, s8_z, s8_v, s8_noop;
  logic [2:0] s8_op;
  logic [1:0] s8_rs1, s8_rs2, s8_rd;

  logic       w_start, w_clr, w_busy, w_valid, w_done, w_c, w_z, w_v, w_noop;
  logic [2:0] w_op;
  logic [0:0] w_rs1, w_rs2, w_rd;

  int checks = 0;
  int errors = 0;
  bit q0m = 1'b0;

  serial_alu_dig #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .reset(reset), .start(s8_start), .op(s8_op), .booth_clr(s8_clr),
    .rs1_d(s8_rs1), .rs2_d(s8_rs2), .busy(s8_busy), .rd_d(s8_rd), .rd_valid(s8_valid),
    .done(s8_done), .flag_c(s8_c), .flag_z(s8_z), .flag_v(s8_v), .booth_noop(s8_noop)
  );

  serial_alu_dig #(.WIDTH(64), .DIGIT(1)) dut64 (
    .clk(clk), .reset(reset), .start(w_start), .op(w_op), .booth_clr(w_clr),
    .rs1_d(w_rs1), .rs2_d(w_rs2), .busy(w_busy), .rd_d(w_rd), .rd_valid(w_valid),
    .done(w_done), .flag_c(w_c), .flag_z(w_z), .flag_v(w_v), .booth_noop(w_noop)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word-level reference: w-bit two's-complement arithmetic and Booth decision.
  function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                input logic [2:0] o, input bit q0, input int w,
                                output logic [63:0] r, output bit c, output bit z,
                                output bit v, output bit noop);
    logic [63:0] mask;
    logic [64:0] s;
    logic [2:0] eff;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    eff = o; noop = 0; c = 0; v = 0;
    if (o == 3'd6) begin
      if (b[0] && !q0) eff = 3'd1;
      else if (!b[0] && q0) eff = 3'd0;
      else begin eff = 3'd5; noop = 1; end
    end
    case (eff)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[63:0] & mask;
        c = s[w];
        v = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
      end
      3'd1: begin
        r = (a - b) & mask;
        c = (a < b);
        v = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      default: r = a;
    endcase
    z = (r == 64'd0);
  endfunction

  // Issues one 8-bit op starting at the current negedge; returns at the
  // negedge of the done cycle so the caller may start the next op there.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                     input bit clr, input bit spurious, input string tag);
    logic [63:0] er;
    bit ec, ez, ev, en;
    logic [7:0] got;
    model({56'd0, a}, {56'd0, b}, o, clr ? 1'b0 : q0m, 8, er, ec, ez, ev, en);
    got = '0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        check({tag, " busy"}, s8_busy, 1);
        check({tag, " valid"}, s8_valid, 1);
        check({tag, " early done"}, s8_done, 0);
        got[2*(k-1) +: 2] = s8_rd;
      end else begin
        check({tag, " idle busy"}, s8_busy, 0);
      end
      s8_start = (k == 0) || (spurious && (k == 1 || k == 2));
      s8_op    = (k == 0) ? o : (o ^ 3'b011);
      s8_clr   = (k == 0) ? clr : spurious;
      s8_rs1   = a[2*k +: 2];
      s8_rs2   = b[2*k +: 2];
      @(negedge clk);
    end
    s8_start = 1'b0;
    s8_clr   = 1'b0;
    check({tag, " last valid"}, s8_valid, 1);
    check({tag, " done"}, s8_done, 1);
    got[7:6] = s8_rd;
    check({tag, " result"}, {56'd0, got}, er);
    check({tag, " flag_c"}, s8_c, ec);
    check({tag, " flag_z"}, s8_z, ez);
    check({tag, " flag_v"}, s8_v, ev);
    check({tag, " noop"}, s8_noop, en);
    if (clr) q0m = 1'b0;
    if (o == 3'd6) q0m = b[0];
  endtask

  task automatic idle8(input string tag);
    s8_start = 1'b0;
    @(negedge clk);
    check({tag, " post done"}, s8_done, 0);
    check({tag, " post valid"}, s8_valid, 0);
  endtask

  task automatic op64(input logic [63:0] a, input logic [63:0] b, input logic [2:0] o,
                      input string tag);
    logic [63:0] er, got;
    bit ec, ez, ev, en;
    int bad;
    model(a, b, o, 1'b0, 64, er, ec, ez, ev, en);
    got = '0;
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      if (k > 0) begin
        if (w_busy !== 1'b1 || w_valid !== 1'b1 || w_done !== 1'b0) bad++;
        got[k-1] = w_rd[0];
      end
      w_start = (k == 0);
      w_op    = o;
      w_rs1   = a[k];
      w_rs2   = b[k];
      @(negedge clk);
    end
    w_start = 1'b0;
    check({tag, " handshake"}, bad, 0);
    check({tag, " done"}, w_done, 1);
    got[63] = w_rd[0];
    check({tag, " result"}, got, er);
    check({tag, " flag_c"}, w_c, ec);
    check({tag, " flag_z"}, w_z, ez);
    check({tag, " flag_v"}, w_v, ev);
    check({tag, " noop"}, w_noop, en);
    @(negedge clk);
    check({tag, " post done"}, w_done, 0);
  endtask

  initial begin
    s8_start = 0; s8_op = 0; s8_clr = 0; s8_rs1 = 0; s8_rs2 = 0;
    w_start = 0; w_op = 0; w_clr = 0; w_rs1 = 0; w_rs2 = 0;

    #1;
    check("rst busy8", s8_busy, 0);
    check("rst rd8", s8_rd, 0);
    check("rst valid8", s8_valid, 0);
    check("rst done8", s8_done, 0);
    check("rst flags8", {s8_c, s8_z, s8_v, s8_noop}, 0);
    check("rst busy64", w_busy, 0);
    check("rst flags64", {w_valid, w_done, w_c, w_z, w_v, w_noop}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    op8(8'h7F, 8'h01, 3'd0, 0, 0, "add7f");
    idle8("add7f");
    op8(8'h05, 8'h07, 3'd1, 0, 0, "sub");
    op8(8'hF0, 8'h0F, 3'd2, 0, 0, "and_b2b");
    idle8("and_b2b");

    op8(8'h10, 8'h01, 3'd6, 1, 0, "booth_sub");
    op8(8'h10, 8'h02, 3'd6, 0, 0, "booth_add");
    op8(8'h5A, 8'h04, 3'd6, 0, 0, "booth_pass");
    idle8("booth_pass");

    op8(8'h3C, 8'h44, 3'd0, 0, 1, "spurious");
    idle8("spurious");

    // Abort mid-operation with an asynchronous reset.
    s8_start = 1; s8_op = 3'd0; s8_rs1 = 2'b11; s8_rs2 = 2'b01;
    @(negedge clk);
    s8_start = 0; s8_rs1 = 2'b10; s8_rs2 = 2'b01;
    @(negedge clk);
    s8_rs1 = 2'b01; s8_rs2 = 2'b10;
    #2 reset = 1'b0;
    #1;
    check("abort busy", s8_busy, 0);
    check("abort valid", s8_valid, 0);
    check("abort rd", s8_rd, 0);
    check("abort done", s8_done, 0);
    @(negedge clk);
    check("abort no done", s8_done, 0);
    reset = 1'b1;
    q0m = 1'b0;
    @(negedge clk);
    op8(8'h01, 8'h01, 3'd0, 0, 0, "add_after_rst");
    op8(8'h22, 8'h03, 3'd6, 0, 0, "booth_after_rst");
    idle8("booth_after_rst");

    for (int i = 0; i < 40; i++) begin
      op8(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
          $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, "rand8");
      if ($urandom_range(0, 1) == 1) idle8("rand8");
    end
    idle8("rand8_end");

    op64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd0, "add64_wrap");
    op64(64'h8000_0000_0000_0000, 64'd1, 3'd1, "sub64_ovf");
    for (int i = 0; i < 3; i++) begin
      logic [2:0] o;
      o = 3'($urandom_range(0, 5));
      op64({$urandom, $urandom}, {$urandom, $urandom}, o, "rand64");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
